// File: rtl/blackjack_pkg.sv
// blackjack_pkg: shared card, deck and dealer-state definitions for the blackjack datapath.
package blackjack_pkg;
    typedef logic [3:0] card_t;
    localparam int DECK_SIZE = 52;
    localparam int RANKS = 13;
    localparam logic [15:0] LFSR_MASK = 16'hB400;
    typedef enum logic [1:0] {INIT, IDLE, SHUFFLE} dealer_state_t;
endpackage

// File: rtl/deck_dealer_lfsr16.sv
// lfsr16: free-running Galois LFSR with seed load; a zero seed falls back to the default to avoid lock-up.
module lfsr16 #(
    parameter logic [15:0] SEED_DEFAULT = 16'hACE1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic [15:0] seed,
    output logic [15:0] value
);
    import blackjack_pkg::*;
    always_ff @(posedge clk) begin
        if (reset)
            value <= SEED_DEFAULT;
        else if (load)
            value <= (seed == '0) ? SEED_DEFAULT : seed;
        else
            value <= value[0] ? ((value >> 1) ^ LFSR_MASK) : (value >> 1);
    end
endmodule

// File: rtl/deck_dealer.sv
// deck_dealer: register-array deck with in-place Fisher-Yates shuffle and a one-card-per-request deal port.
module deck_dealer #(
    parameter int DECK_SIZE = blackjack_pkg::DECK_SIZE,
    parameter int LFSR_W = 16,
    parameter logic [LFSR_W-1:0] SEED_DEFAULT = 16'hACE1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              loadseed_i,
    input  logic [LFSR_W-1:0] seed_i,
    input  logic              shuffle_i,
    input  logic              card_req_i,
    output logic [3:0]        card_o,
    output logic              card_valid_o,
    output logic              busy_o,
    output logic              empty_o,
    output logic [5:0]        cards_left_o
);
    import blackjack_pkg::*;
    dealer_state_t state;
    card_t deck [DECK_SIZE];
    card_t rank;
    logic [5:0] idx, ptr, i, j;
    logic [LFSR_W-1:0] lfsr;
    logic lfsr_unused;
    lfsr16 #(.SEED_DEFAULT(SEED_DEFAULT)) u_lfsr (
        .clk(clk),
        .reset(reset),
        .load(loadseed_i),
        .seed(seed_i),
        .value(lfsr)
    );
    assign j = lfsr[5:0];
    assign lfsr_unused = ^lfsr[LFSR_W-1:6];
    assign empty_o = (cards_left_o == '0);
    // Rejected draws (j > i) simply retry next cycle with the advanced LFSR.
    always_ff @(posedge clk) begin
        card_valid_o <= 1'b0;
        if (reset) begin
            state        <= INIT;
            idx          <= '0;
            rank         <= 4'd1;
            ptr          <= '0;
            i            <= '0;
            card_o       <= '0;
            busy_o       <= 1'b1;
            cards_left_o <= '0;
        end else begin
            case (state)
                INIT: begin
                    deck[idx] <= rank;
                    idx       <= idx + 6'd1;
                    rank      <= (rank == 4'(RANKS)) ? 4'd1 : rank + 4'd1;
                    if (idx == 6'(DECK_SIZE - 1)) begin
                        state        <= IDLE;
                        busy_o       <= 1'b0;
                        ptr          <= '0;
                        cards_left_o <= 6'(DECK_SIZE);
                    end
                end
                IDLE: begin
                    if (shuffle_i) begin
                        state  <= SHUFFLE;
                        busy_o <= 1'b1;
                        i      <= 6'(DECK_SIZE - 1);
                    end else if (card_req_i && cards_left_o != '0) begin
                        card_valid_o <= 1'b1;
                        card_o       <= deck[ptr];
                        ptr          <= ptr + 6'd1;
                        cards_left_o <= cards_left_o - 6'd1;
                    end
                end
                SHUFFLE: begin
                    if (j <= i) begin
                        deck[i] <= deck[j];
                        deck[j] <= deck[i];
                        i       <= i - 6'd1;
                        if (i == 6'd1) begin
                            state        <= IDLE;
                            busy_o       <= 1'b0;
                            ptr          <= '0;
                            cards_left_o <= 6'(DECK_SIZE);
                        end
                    end
                end
                default: state <= INIT;
            endcase
        end
    end
endmodule

// File: tb/tb_deck_dealer.sv
// tb_deck_dealer: scoreboard bench with a reference Fisher-Yates model and a boundary-vector table.
module tb_deck_dealer;
    logic clk = 0, reset = 1, loadseed_i = 0, shuffle_i = 0, card_req_i = 0;
    logic [15:0] seed_i = '0;
    logic [3:0] card_o;
    logic card_valid_o, busy_o, empty_o;
    logic [5:0] cards_left_o;
    int n_vec = 0, n_err = 0;
    int sb[$];
    int got[$];
    int mdeck[52];
    int seq0[52];
    typedef struct {bit req; bit shuf; bit valid; bit busy; int left;} vec_t;
    vec_t vecs[6];
    logic [15:0] seeds[4];

    deck_dealer dut (
        .clk(clk), .reset(reset), .loadseed_i(loadseed_i), .seed_i(seed_i),
        .shuffle_i(shuffle_i), .card_req_i(card_req_i), .card_o(card_o),
        .card_valid_o(card_valid_o), .busy_o(busy_o), .empty_o(empty_o),
        .cards_left_o(cards_left_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (card_valid_o) begin
            got.push_back(int'(card_o));
            if (sb.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_card: got %0d, expected no card", card_o);
            end else
                chk("card", int'(card_o), sb.pop_front());
        end
    end

    function automatic int model_shuffle(input logic [15:0] s);
        logic [15:0] l;
        int i, c, t, j;
        l = (s == 16'h0) ? 16'hACE1 : s;
        i = 51;
        c = 0;
        while (i >= 1) begin
            j = int'(l[5:0]);
            if (j <= i) begin
                t = mdeck[i];
                mdeck[i] = mdeck[j];
                mdeck[j] = t;
                i--;
            end
            l = l[0] ? ((l >> 1) ^ 16'hB400) : (l >> 1);
            c++;
        end
        return c;
    endfunction

    // Reset, then sit through INIT poking requests and shuffles that must be ignored.
    task automatic do_reset();
        bit ok;
        reset = 1; card_req_i = 0; shuffle_i = 0; loadseed_i = 0;
        step();
        reset = 0;
        chk("rst_card", int'(card_o), 0);
        chk("rst_valid", int'(card_valid_o), 0);
        chk("rst_busy", int'(busy_o), 1);
        chk("rst_empty", int'(empty_o), 1);
        chk("rst_left", int'(cards_left_o), 0);
        ok = 1;
        for (int k = 1; k <= 51; k++) begin
            card_req_i = k[0];
            shuffle_i = (k % 7 == 0);
            step();
            if (!busy_o || card_valid_o || !empty_o) ok = 0;
        end
        card_req_i = 0; shuffle_i = 0;
        chk("init_busy_hold", int'(ok), 1);
        step();
        chk("init_done_busy", int'(busy_o), 0);
        chk("init_done_left", int'(cards_left_o), 52);
        chk("init_done_empty", int'(empty_o), 0);
        for (int k = 0; k < 52; k++) mdeck[k] = k % 13 + 1;
    endtask

    task automatic deal_all();
        got.delete();
        for (int k = 0; k < 52; k++) begin
            sb.push_back(mdeck[k]);
            card_req_i = 1;
            step();
        end
        card_req_i = 0;
        step();
        step();
        chk("sb_drained", sb.size(), 0);
        chk("deal_count", got.size(), 52);
        chk("empty_after_deal", int'(empty_o), 1);
        chk("left_after_deal", int'(cards_left_o), 0);
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (busy_o && n < 5000) begin
            step();
            n++;
        end
    endtask

    initial begin
        int n, c, diffs;
        int cnt[14];
        vecs[0] = '{1, 0, 0, 0, 0};
        vecs[1] = '{0, 0, 0, 0, 0};
        vecs[2] = '{1, 1, 0, 1, 0};
        vecs[3] = '{1, 0, 0, 1, 0};
        vecs[4] = '{0, 1, 0, 1, 0};
        vecs[5] = '{1, 0, 0, 1, 0};
        seeds[0] = 16'h1234; seeds[1] = 16'h1234; seeds[2] = 16'h4321; seeds[3] = 16'h0000;

        do_reset();
        deal_all();
        chk("card_hold", int'(card_o), 13);

        foreach (vecs[v]) begin
            card_req_i = vecs[v].req;
            shuffle_i = vecs[v].shuf;
            step();
            chk($sformatf("vec%0d_valid", v), int'(card_valid_o), int'(vecs[v].valid));
            chk($sformatf("vec%0d_busy", v), int'(busy_o), int'(vecs[v].busy));
            chk($sformatf("vec%0d_left", v), int'(cards_left_o), vecs[v].left);
        end
        card_req_i = 0; shuffle_i = 0;
        wait_idle(n);
        chk("reshuffle_done", int'(busy_o), 0);
        chk("reshuffle_left", int'(cards_left_o), 52);

        foreach (seeds[s]) begin
            do_reset();
            seed_i = seeds[s];
            loadseed_i = 1;
            shuffle_i = 1;
            step();
            loadseed_i = 0; shuffle_i = 0;
            chk("lfsr_loaded", int'(dut.u_lfsr.value), (seeds[s] == 0) ? 'hACE1 : int'(seeds[s]));
            chk("shuffle_busy", int'(busy_o), 1);
            c = model_shuffle(seeds[s]);
            wait_idle(n);
            chk("shuffle_cycles", n, c);
            deal_all();
            for (int r = 0; r < 14; r++) cnt[r] = 0;
            foreach (got[k]) if (got[k] >= 1 && got[k] <= 13) cnt[got[k]]++;
            for (int r = 1; r <= 13; r++) chk($sformatf("rank%0d_count", r), cnt[r], 4);
            diffs = 0;
            if (s == 0) foreach (seq0[k]) seq0[k] = got[k];
            else foreach (seq0[k]) if (got.size() > k && got[k] != seq0[k]) diffs++;
            if (s == 1) chk("same_seed_same_seq", diffs, 0);
            if (s == 2) chk("other_seed_differs", int'(diffs > 0), 1);
        end

        shuffle_i = 1;
        step();
        shuffle_i = 0;
        repeat (20) step();
        chk("mid_shuffle_busy", int'(busy_o), 1);
        do_reset();
        deal_all();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, expected finish");
        $fatal(1);
    end
endmodule

// File: doc/deck_dealer.md
# deck_dealer

Card source that feeds `blackjack_states`. Holds a 52-card deck of 4-bit ranks, shuffles it in place (Fisher-Yates driven by a seeded 16-bit LFSR) and deals one card per request through a request/valid handshake. Sits directly upstream of the game state machine. `loadseed_i` is shared with the game state machine.

## Interface
- `DECK_SIZE`, 52, cards in deck; must be a multiple of 13 and ≤ 64.
- `LFSR_W`, 16, LFSR width.
- `SEED_DEFAULT`, 16'hACE1, LFSR value after reset; also substituted whenever a zero seed is loaded.

- `clk` in 1: system clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `loadseed_i` in 1: one-cycle pulse; load `seed_i` into the LFSR.
- `seed_i` in 16: seed value.
- `shuffle_i` in 1: one-cycle pulse; start a shuffle.
- `card_req_i` in 1: one-cycle pulse; request the next card.
- `card_o` in/out 4 (out): dealt rank, 1..13 (1 = ace, 11..13 = J/Q/K).
- `card_valid_o` out 1: one-cycle pulse qualifying `card_o`.
- `busy_o` out 1: high in INIT and SHUFFLE.
- `empty_o` out 1: high when no cards remain.
- `cards_left_o` out 6: undealt count.

## Operation
- Reset values:
  - `card_o` = 0, `card_valid_o` = 0.
  - `busy_o` = 1, `empty_o` = 1, `cards_left_o` = 0.
  - LFSR = `SEED_DEFAULT`; state = INIT, index = 0.
- LFSR:
  - Galois, polynomial x^16+x^14+x^13+x^11+1 (mask 16'hB400).
  - Free-runs, advancing every cycle in every state except the reset cycle.
  - On `loadseed_i`, the next value is `seed_i`, or `SEED_DEFAULT` if `seed_i` == 0.
- INIT:
  - Writes `deck[k] = (k mod 13) + 1` for k = 0..51, one entry per cycle.
  - Then goes to IDLE with `cards_left_o` = 52 and deal pointer = 0.
- IDLE:
  - `shuffle_i` → SHUFFLE, with i = 51.
  - Otherwise, `card_req_i` with `cards_left_o` > 0 → next cycle `card_valid_o` = 1, `card_o` = `deck[ptr]`; ptr++ and `cards_left_o`--.
- SHUFFLE, one attempt per cycle:
  - j = `lfsr[5:0]`.
  - If j ≤ i: swap `deck[i]` and `deck[j]` (j == i is a legal no-op swap), then i--.
  - Else: retry next cycle.
  - After the swap at i = 1, go to IDLE, reset ptr to 0 and set `cards_left_o` = 52.
  - A shuffle always covers all 52 positions, dealt or not.
- Boundary rules:
  - Request with `cards_left_o` = 0: no `card_valid_o`; `empty_o` stays 1.
  - `card_req_i` while `busy_o` = 1: ignored, not queued.
  - `shuffle_i` in INIT or SHUFFLE: ignored.
  - `shuffle_i` and `card_req_i` in the same IDLE cycle: shuffle wins; no card is dealt.
  - `loadseed_i` with `shuffle_i`: both act. The seed loads, and the first SHUFFLE attempt (next cycle) uses the seed value.
  - `loadseed_i` mid-SHUFFLE: LFSR reloads; the shuffle continues from the current i.
  - `reset` mid-SHUFFLE or mid-deal: full return to INIT, which re-orders the deck.
- `empty_o` = (`cards_left_o` == 0) in all states. It therefore stays 1 during INIT and SHUFFLE until the deck becomes ready.

## Timing
- Reset deasserted at edge 0: INIT writes on edges 1..52. `busy_o` falls and `cards_left_o` = 52 after edge 52.
- Shuffle start: `shuffle_i` sampled at edge N gives `busy_o` = 1 after edge N.
  - Minimum duration 51 cycles; each rejection adds 1 cycle.
  - `busy_o` falls on the edge that performs the i = 1 swap.
- Deal: `card_req_i` sampled at edge N gives `card_valid_o`/`card_o` valid after edge N, for exactly one cycle.
  - `cards_left_o` updates on the same edge.
  - Back-to-back requests give one card per cycle.
- `card_o` holds its last value when `card_valid_o` = 0.

## Structure
- `blackjack_pkg` holds:
  - `card_t` (logic [3:0]);
  - `DECK_SIZE`, `RANKS` = 13;
  - the `dealer_state_t` enum {INIT, IDLE, SHUFFLE};
  - `LFSR_MASK`.
- Sub-module `lfsr16`: ports clk, reset, load, seed, value. It handles the zero-seed substitution.
- The deck is a register array (`card_t deck[DECK_SIZE]`), so the same-cycle two-entry swap needs no RAM.

## Test plan
- Reset, then 52 idle cycles, then 52 requests with no shuffle → cards 1,2,…,13 repeated 4 times. `empty_o` = 1 after the 52nd card.
- `seed_i` = 16'h1234, load, shuffle, wait for `!busy_o`, deal 52 → each rank 1..13 appears exactly 4 times. Repeating with the same seed and cycle offsets gives an identical sequence; seed 16'h4321 gives a different sequence.
- 53rd request on an empty deck → no `card_valid_o`, `cards_left_o` stays 0. A following shuffle restores 52.
- `card_req_i` during INIT and during SHUFFLE → no `card_valid_o`. `shuffle_i` and `card_req_i` in the same IDLE cycle → `busy_o` = 1 next cycle and no card.
- `seed_i` = 0 loaded → LFSR value equals 16'hACE1 after the load edge (no lock-up).
- `reset` asserted 20 cycles into a shuffle → `busy_o` stays 1 through INIT. The subsequent unshuffled deal yields 1..13 ordered.
